// File: rtl/gmii_rx_pkt_assembler_pkg.sv
// rtl/gmii_rx_pkt_assembler_pkg.sv - shared constants, state enum and tag helper for the GMII rx packet assembler
package gmii_rx_pkt_assembler_pkg;

   localparam int         PKT_W      = 134;
   localparam int         FCS_BYTES  = 4;
   localparam logic [1:0] TAG_HEAD   = 2'b01;
   localparam logic [1:0] TAG_MID    = 2'b00;
   localparam logic [1:0] TAG_TAIL   = 2'b10;
   localparam logic [1:0] TAG_SINGLE = 2'b11;
   localparam logic [7:0] PREAMBLE   = 8'h55;
   localparam logic [7:0] SFD        = 8'hD5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_DATA,
      ST_DISC
   } rx_state_t;

   function automatic logic [1:0] beat_tag(input logic head, input logic tail);
      if (head && tail) return TAG_SINGLE;
      else if (head)    return TAG_HEAD;
      else if (tail)    return TAG_TAIL;
      else              return TAG_MID;
   endfunction

endpackage

// File: rtl/gmii_rx_pkt_assembler_fcs_strip_dly.sv
// rtl/gmii_rx_pkt_assembler_fcs_strip_dly.sv - 4-stage byte delay line that withholds the trailing FCS bytes
module fcs_strip_dly
   import gmii_rx_pkt_assembler_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_vld,
   input  logic [7:0] i_data,
   output logic       o_vld,
   output logic [7:0] o_data
);

   logic [7:0]           r_data [FCS_BYTES];
   logic [FCS_BYTES-1:0] r_vld;

   // A byte only leaves once the line is full, so the last FCS_BYTES bytes never do.
   assign o_vld  = i_vld & r_vld[FCS_BYTES-1];
   assign o_data = r_data[FCS_BYTES-1];

   always_ff @(posedge clk) begin
      if (!rst_n || i_clr) begin
         r_vld <= '0;
         for (int i = 0; i < FCS_BYTES; i++) r_data[i] <= 8'h00;
      end else if (i_vld) begin
         r_vld     <= {r_vld[FCS_BYTES-2:0], 1'b1};
         r_data[0] <= i_data;
         for (int i = 1; i < FCS_BYTES; i++) r_data[i] <= r_data[i-1];
      end
   end

endmodule

// File: rtl/gmii_rx_pkt_assembler.sv
// rtl/gmii_rx_pkt_assembler.sv - strips preamble/SFD/FCS from GMII rx and packs payload into 134b beats
// MAX_BYTES must not be 1 more than a multiple of 16 (the forced tail would collide with a held beat).
module gmii_rx_pkt_assembler
   import gmii_rx_pkt_assembler_pkg::*;
#(
   parameter int STRIP_FCS = 1,
   parameter int MAX_BYTES = 2048
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             gmii_rx_dv,
   input  logic             gmii_rx_er,
   input  logic [7:0]       gmii_rxd,
   output logic             pktData_valid,
   output logic [PKT_W-1:0] pktData,
   output logic [31:0]      pkt_cnt,
   output logic [31:0]      err_cnt
);

   localparam int CNT_W = $clog2(MAX_BYTES + 1);

   rx_state_t        r_state;
   logic [CNT_W-1:0] r_byte_cnt;
   logic [127:0]     r_beat;
   logic [4:0]       r_beat_n;
   logic             r_first;
   logic             r_out_vld;
   logic [PKT_W-1:0] r_out;
   logic [31:0]      r_pkt_cnt;
   logic [31:0]      r_err_cnt;

   logic             w_in_vld;
   logic             w_pay_vld;
   logic [7:0]       w_pay_byte;
   logic             w_last;
   logic [4:0]       w_n_base;
   logic [127:0]     w_beat_ins;

   assign w_in_vld = (r_state == ST_DATA) & gmii_rx_dv & ~gmii_rx_er;

   generate
      if (STRIP_FCS != 0) begin : g_strip
         fcs_strip_dly u_dly (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_clr  (~w_in_vld),
            .i_vld  (w_in_vld),
            .i_data (gmii_rxd),
            .o_vld  (w_pay_vld),
            .o_data (w_pay_byte)
         );
      end else begin : g_pass
         assign w_pay_vld  = w_in_vld;
         assign w_pay_byte = gmii_rxd;
      end
   endgenerate

   assign w_last = w_pay_vld && (r_byte_cnt == CNT_W'(MAX_BYTES - 1));

   // A full beat sitting in r_beat is the held beat; the next byte starts a fresh one.
   always_comb begin
      w_n_base   = (r_beat_n == 5'd16) ? 5'd0 : r_beat_n;
      w_beat_ins = (r_beat_n == 5'd16) ? '0 : r_beat;
      for (int k = 0; k < 16; k++) begin
         if (w_n_base == 5'(k)) w_beat_ins[8*(15-k) +: 8] = w_pay_byte;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_byte_cnt <= '0;
         r_beat     <= '0;
         r_beat_n   <= '0;
         r_first    <= 1'b1;
         r_out_vld  <= 1'b0;
         r_out      <= '0;
         r_pkt_cnt  <= '0;
         r_err_cnt  <= '0;
      end else begin
         r_out_vld <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (gmii_rx_dv)
                  r_state <= (gmii_rxd == PREAMBLE && !gmii_rx_er) ? ST_PRE : ST_DISC;
            end
            ST_PRE: begin
               if (!gmii_rx_dv)                r_state <= ST_IDLE;
               else if (gmii_rx_er)            r_state <= ST_DISC;
               else if (gmii_rxd == SFD) begin
                  r_state    <= ST_DATA;
                  r_byte_cnt <= '0;
                  r_beat     <= '0;
                  r_beat_n   <= '0;
                  r_first    <= 1'b1;
               end else if (gmii_rxd != PREAMBLE) r_state <= ST_DISC;
            end
            ST_DATA: begin
               if (!gmii_rx_dv || gmii_rx_er) begin
                  r_state <= gmii_rx_dv ? ST_DISC : ST_IDLE;
                  if (r_byte_cnt == '0) begin
                     r_err_cnt <= r_err_cnt + 32'd1;
                  end else begin
                     r_out     <= {beat_tag(r_first, 1'b1), 4'(r_beat_n - 5'd1), r_beat};
                     r_out_vld <= 1'b1;
                     if (gmii_rx_dv) r_err_cnt <= r_err_cnt + 32'd1;
                     else            r_pkt_cnt <= r_pkt_cnt + 32'd1;
                  end
               end else if (w_pay_vld) begin
                  r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                  r_beat     <= w_beat_ins;
                  r_beat_n   <= w_n_base + 5'd1;
                  if (r_beat_n == 5'd16) begin
                     r_out     <= {beat_tag(r_first, 1'b0), 4'hF, r_beat};
                     r_out_vld <= 1'b1;
                     r_first   <= 1'b0;
                  end
                  if (w_last) begin
                     r_state   <= ST_DISC;
                     r_err_cnt <= r_err_cnt + 32'd1;
                     r_out     <= {beat_tag(r_first && (r_beat_n != 5'd16), 1'b1),
                                   w_n_base[3:0], w_beat_ins};
                     r_out_vld <= 1'b1;
                  end
               end
            end
            ST_DISC: begin
               if (!gmii_rx_dv) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign pktData_valid = r_out_vld;
   assign pktData       = r_out;
   assign pkt_cnt       = r_pkt_cnt;
   assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_gmii_rx_pkt_assembler.sv
// tb/tb_gmii_rx_pkt_assembler.sv - randomized bench comparing two assembler builds against a frame-level model
module tb_gmii_rx_pkt_assembler;
   import gmii_rx_pkt_assembler_pkg::*;

   localparam int MAXB = 2048;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         dv = 1'b0;
   logic         er = 1'b0;
   logic [7:0]   rxd = 8'h00;
   logic         v1, v0;
   logic [133:0] d1, d0;
   logic [31:0]  p1, e1, p0, e0;

   always #4 clk = ~clk;

   gmii_rx_pkt_assembler #(.STRIP_FCS(1), .MAX_BYTES(MAXB)) u_dut_fcs1 (
      .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rxd(rxd),
      .pktData_valid(v1), .pktData(d1), .pkt_cnt(p1), .err_cnt(e1));

   gmii_rx_pkt_assembler #(.STRIP_FCS(0), .MAX_BYTES(MAXB)) u_dut_fcs0 (
      .clk(clk), .rst_n(rst_n), .gmii_rx_dv(dv), .gmii_rx_er(er), .gmii_rxd(rxd),
      .pktData_valid(v0), .pktData(d0), .pkt_cnt(p0), .err_cnt(e0));

   logic [133:0] obs1[$], obs0[$], exp1[$], exp0[$], pred[$];
   logic [7:0]   pre_q[$], fbuf[$];
   int           er_idx;
   int           n_tests = 0;
   int           n_fail = 0;
   logic [31:0]  epk1 = 0, eer1 = 0, epk0 = 0, eer0 = 0;
   logic [133:0] last1 = '0, last0 = '0;

   always @(negedge clk) begin
      if (v1) obs1.push_back(d1);
      if (v0) obs0.push_back(d0);
   end

   task automatic check(input string tag, input logic [133:0] got, input logic [133:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic e, input logic [7:0] b);
      @(posedge clk);
      #1;
      dv  = v;
      er  = e;
      rxd = b;
   endtask

   task automatic mk(input int npre, input int len, input int eidx, input bit seq);
      pre_q.delete();
      fbuf.delete();
      repeat (npre) pre_q.push_back(PREAMBLE);
      pre_q.push_back(SFD);
      for (int i = 0; i < len; i++) fbuf.push_back(seq ? 8'(i) : 8'($urandom));
      er_idx = eidx;
   endtask

   // Frame-level rules: payload = bytes before the error (or all), minus FCS, capped at MAXB.
   task automatic predict(input bit strip, input bit pre_ok, output int dpk, output int der);
      int           len, n, nb, cnt;
      bit           trunc;
      logic [127:0] data;
      pred.delete();
      dpk = 0;
      der = 0;
      if (!pre_ok) return;
      len   = (er_idx >= 0) ? er_idx : fbuf.size();
      n     = strip ? len - 4 : len;
      if (n < 0) n = 0;
      trunc = (n >= MAXB);
      if (trunc) n = MAXB;
      if (n == 0) begin
         der = 1;
         return;
      end
      nb = (n + 15) / 16;
      for (int b = 0; b < nb; b++) begin
         cnt  = (n - 16*b > 16) ? 16 : n - 16*b;
         data = '0;
         for (int k = 0; k < cnt; k++) data[127-8*k -: 8] = fbuf[16*b+k];
         pred.push_back({b == nb-1, b == 0, 4'(cnt-1), data});
      end
      if (trunc || er_idx >= 0) der = 1;
      else                      dpk = 1;
   endtask

   task automatic verify();
      check("n_beats_fcs1", 134'(obs1.size()), 134'(exp1.size()));
      for (int i = 0; i < exp1.size() && i < obs1.size(); i++)
         check($sformatf("beat_fcs1_%0d", i), obs1[i], exp1[i]);
      check("n_beats_fcs0", 134'(obs0.size()), 134'(exp0.size()));
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++)
         check($sformatf("beat_fcs0_%0d", i), obs0[i], exp0[i]);
      check("pkt_cnt_fcs1", 134'(p1), 134'(epk1));
      check("err_cnt_fcs1", 134'(e1), 134'(eer1));
      check("pkt_cnt_fcs0", 134'(p0), 134'(epk0));
      check("err_cnt_fcs0", 134'(e0), 134'(eer0));
      check("hold_fcs1", d1, last1);
      check("hold_fcs0", d0, last0);
      obs1.delete();
      obs0.delete();
      exp1.delete();
      exp0.delete();
   endtask

   task automatic run_frame();
      bit pre_ok;
      int dpk, der;
      pre_ok = (pre_q.size() >= 2) && (pre_q[pre_q.size()-1] == SFD);
      for (int i = 0; i < pre_q.size() - 1; i++)
         if (pre_q[i] != PREAMBLE) pre_ok = 0;
      foreach (pre_q[i]) drive(1'b1, 1'b0, pre_q[i]);
      foreach (fbuf[i]) drive(1'b1, i == er_idx, fbuf[i]);
      repeat (14) drive(1'b0, 1'b0, 8'($urandom));
      predict(1'b1, pre_ok, dpk, der);
      foreach (pred[i]) exp1.push_back(pred[i]);
      if (pred.size() > 0) last1 = pred[pred.size()-1];
      epk1 += 32'(dpk);
      eer1 += 32'(der);
      predict(1'b0, pre_ok, dpk, der);
      foreach (pred[i]) exp0.push_back(pred[i]);
      if (pred.size() > 0) last0 = pred[pred.size()-1];
      epk0 += 32'(dpk);
      eer0 += 32'(der);
      verify();
   endtask

   task automatic run_reset_frame();
      logic [127:0] data;
      mk(7, 64, -1, 1);
      foreach (pre_q[i]) drive(1'b1, 1'b0, pre_q[i]);
      foreach (fbuf[i]) begin
         @(posedge clk);
         #1;
         dv    = 1'b1;
         er    = 1'b0;
         rxd   = fbuf[i];
         rst_n = (i != 30);
      end
      repeat (14) drive(1'b0, 1'b0, 8'h00);
      // Only the head beat (bytes 0..15) gets out before the reset; nothing after it.
      data = '0;
      for (int k = 0; k < 16; k++) data[127-8*k -: 8] = 8'(k);
      exp1.push_back({TAG_HEAD, 4'hF, data});
      exp0.push_back({TAG_HEAD, 4'hF, data});
      epk1 = 0; eer1 = 0; epk0 = 0; eer0 = 0;
      last1 = '0;
      last0 = '0;
      verify();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int len, eidx;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_fcs1", 134'(v1), 134'(0));
      check("rst_data_fcs1", d1, '0);
      check("rst_pkt_fcs1", 134'(p1), 134'(0));
      check("rst_err_fcs1", 134'(e1), 134'(0));
      check("rst_valid_fcs0", 134'(v0), 134'(0));
      check("rst_data_fcs0", d0, '0);
      rst_n = 1'b1;
      repeat (2) drive(1'b0, 1'b0, 8'h00);

      mk(7, 64, -1, 1);  run_frame();
      mk(7, 36, -1, 1);  run_frame();
      mk(7, 20, -1, 1);  run_frame();
      mk(7, 3, -1, 1);   run_frame();
      mk(7, 100, 20, 1); run_frame();
      mk(3, 64, -1, 1);
      pre_q[3] = 8'h12;
      run_frame();
      mk(7, 64, -1, 1);  run_frame();
      mk(1, 0, -1, 1);   run_frame();
      mk(7, 3, 1, 1);    run_frame();
      run_reset_frame();
      mk(7, 64, -1, 1);  run_frame();
      mk(7, 2051, -1, 0); run_frame();
      mk(7, 2052, -1, 0); run_frame();
      mk(7, 2100, -1, 0); run_frame();

      for (int f = 0; f < 40; f++) begin
         len  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 90));
         eidx = -1;
         if (len > 0 && $urandom_range(0, 3) == 0) eidx = int'($urandom_range(0, len - 1));
         mk(int'($urandom_range(1, 7)), len, eidx, 0);
         if ($urandom_range(0, 7) == 0)
            pre_q[$urandom_range(0, pre_q.size() - 1)] = 8'h12;
         run_frame();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
